// File: rtl/ht_delay_meas_ctrl.sv
// Two-phase ring-oscillator measurement sequencer for a Trojan-instrumented delay path.
// Counts loop oscillations with the trigger off, then on, and flags a large difference.
module ht_delay_meas_ctrl #(
  parameter int unsigned CW     = 16,
  parameter int unsigned SETTLE = 16,
  parameter int unsigned WINDOW = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] thresh,
  input  logic          path_out,
  output logic          path_in,
  output logic          ht_in1,
  output logic          ht_in2,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b,
  output logic [CW-1:0] delta,
  output logic          alarm
);

  localparam int unsigned TMax = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int unsigned TW   = $clog2(TMax + 1);
  localparam logic [TW-1:0] SettleLast = TW'(SETTLE - 1);
  localparam logic [TW-1:0] WindowLast = TW'(WINDOW - 1);
  localparam logic [CW-1:0] CntMax     = '1;

  typedef enum logic [2:0] {
    StIdle, StSettleA, StMeasA, StGap, StMeasB, StCompare, StDone
  } state_e;

  state_e        state_q;
  logic [TW-1:0] tmr_q;
  logic          ro_en_q;
  logic          trig_q;
  logic          meta_q;
  logic          sync_q;
  logic          sync_qq;
  logic [CW-1:0] acc_a_q;
  logic [CW-1:0] acc_b_q;
  logic [CW-1:0] thresh_q;
  logic [CW-1:0] diff;
  logic          edge_det;

  // Trigger off: non-inverting path, so feedback inverts; trigger on: feedback passes through.
  assign path_in  = ro_en_q & ~(path_out ^ trig_q);
  assign ht_in1   = trig_q;
  assign ht_in2   = trig_q;
  assign edge_det = sync_q & ~sync_qq;
  assign diff     = (acc_a_q >= acc_b_q) ? (acc_a_q - acc_b_q) : (acc_b_q - acc_a_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_qq <= 1'b0;
    end else begin
      meta_q  <= path_out;
      sync_q  <= meta_q;
      sync_qq <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      tmr_q    <= '0;
      ro_en_q  <= 1'b0;
      trig_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_a_q  <= '0;
      acc_b_q  <= '0;
      thresh_q <= '0;
      cnt_a    <= '0;
      cnt_b    <= '0;
      delta    <= '0;
      alarm    <= 1'b0;
    end else if (abort && (state_q != StIdle)) begin
      // Results are left untouched so the last completed measurement stays visible.
      state_q <= StIdle;
      tmr_q   <= '0;
      ro_en_q <= 1'b0;
      trig_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSettleA;
            tmr_q    <= '0;
            busy     <= 1'b1;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            thresh_q <= thresh;
          end
        end
        StSettleA: begin
          if (tmr_q == SettleLast) begin
            state_q <= StMeasA;
            tmr_q   <= '0;
            ro_en_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StMeasA: begin
          if (edge_det && (acc_a_q != CntMax)) acc_a_q <= acc_a_q + 1'b1;
          if (tmr_q == WindowLast) begin
            state_q <= StGap;
            tmr_q   <= '0;
            ro_en_q <= 1'b0;
            trig_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StGap: begin
          if (tmr_q == SettleLast) begin
            state_q <= StMeasB;
            tmr_q   <= '0;
            ro_en_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StMeasB: begin
          if (edge_det && (acc_b_q != CntMax)) acc_b_q <= acc_b_q + 1'b1;
          if (tmr_q == WindowLast) begin
            state_q <= StCompare;
            tmr_q   <= '0;
            ro_en_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        StCompare: begin
          state_q <= StDone;
          trig_q  <= 1'b0;
          done    <= 1'b1;
          cnt_a   <= acc_a_q;
          cnt_b   <= acc_b_q;
          delta   <= diff;
          alarm   <= (diff > thresh_q);
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ht_delay_meas_ctrl.sv
// Bench for ht_delay_meas_ctrl: synchronous delay-line path models close the ring; counts are
// predicted from the logged path output and the measurement window arithmetic.
module tb_ht_delay_meas_ctrl;
  localparam int unsigned CW = 16;
  localparam int unsigned S  = 8;
  localparam int unsigned W  = 64;
  localparam int DoneRel = 2 * S + 2 * W + 2;
  localparam int MeasA0  = S + 1;
  localparam int MeasA1  = S + W;
  localparam int MeasB0  = 2 * S + W + 1;
  localparam int MeasB1  = 2 * S + 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, sat_en;
  logic [CW-1:0] thresh;
  logic          path_out, path_in, ht_in1, ht_in2, busy, done, alarm;
  logic [CW-1:0] cnt_a, cnt_b, delta;

  logic          start_s, path_out_s, path_in_s, ht_s1, ht_s2, busy_s, done_s, alarm_s;
  logic [2:0]    cnt_a_s, cnt_b_s, delta_s;

  ht_delay_meas_ctrl #(.CW(CW), .SETTLE(S), .WINDOW(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .thresh(thresh),
    .path_out(path_out), .path_in(path_in), .ht_in1(ht_in1), .ht_in2(ht_in2),
    .busy(busy), .done(done), .cnt_a(cnt_a), .cnt_b(cnt_b), .delta(delta), .alarm(alarm)
  );

  ht_delay_meas_ctrl #(.CW(3), .SETTLE(S), .WINDOW(W)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .abort(1'b0), .thresh(3'd0),
    .path_out(path_out_s), .path_in(path_in_s), .ht_in1(ht_s1), .ht_in2(ht_s2),
    .busy(busy_s), .done(done_s), .cnt_a(cnt_a_s), .cnt_b(cnt_b_s), .delta(delta_s),
    .alarm(alarm_s)
  );

  assign start_s = start & sat_en;

  // Path models: delay line of path_in history, inverting when the trigger is on.
  logic [31:0] hist, hist_s;
  logic [4:0]  d_off, d_on;
  logic        inv_on;
  always @(posedge clk) hist   <= rst ? 32'd0 : {hist[30:0], path_in};
  always @(posedge clk) hist_s <= rst ? 32'd0 : {hist_s[30:0], path_in_s};
  assign path_out   = (ht_in1 & ht_in2) ? (hist[d_on - 5'd1] ^ inv_on) : hist[d_off - 5'd1];
  assign path_out_s = (ht_s1 & ht_s2) ? ~hist_s[1] : hist_s[1];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   logging = 1'b0;
  logic po_log [0:511];
  int   m_a, m_b, m_d;
  logic m_al;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (logging && (cyc - t0) >= 0 && (cyc - t0) < 512) po_log[cyc - t0] = path_out;
  endtask

  // Rising edges of path_out at cycle t are seen by the counters at t+2.
  function automatic int model_cnt(input int lo, input int hi, input int maxv);
    int n = 0;
    for (int t = 1; t + 2 <= hi; t++)
      if (t + 2 >= lo && po_log[t] === 1'b1 && po_log[t-1] === 1'b0) n++;
    return (n > maxv) ? maxv : n;
  endfunction

  task automatic check_results(input string tag);
    check({tag, "_cnt_a"}, cnt_a, m_a);
    check({tag, "_cnt_b"}, cnt_b, m_b);
    check({tag, "_delta"}, delta, m_d);
    check({tag, "_alarm"}, alarm, m_al);
  endtask

  task automatic run_meas(input int th, input int abort_at, input bit ign);
    bit   in_a, in_b;
    logic pe;
    thresh  = CW'(th);
    start   = 1'b1;
    t0      = cyc;
    logging = 1'b1;
    po_log[0] = path_out;
    for (int k = 1; k <= DoneRel + 1; k++) begin
      tick();
      start  = ign && (k == 5 || k == DoneRel);
      abort  = (k == abort_at);
      thresh = CW'($urandom());
      if (abort_at > 0 && k == abort_at + 1) begin
        check("abort_busy", busy, 0);
        check("abort_ht1", ht_in1, 0);
        check("abort_ht2", ht_in2, 0);
        check("abort_path_in", path_in, 0);
        check("abort_done", done, 0);
        check_results("abort");
        logging = 1'b0;
        return;
      end
      in_a = (k >= MeasA0 && k <= MeasA1);
      in_b = (k >= MeasB0 && k <= MeasB1);
      if (k == DoneRel) begin
        m_a  = model_cnt(MeasA0, MeasA1, 2 ** CW - 1);
        m_b  = model_cnt(MeasB0, MeasB1, 2 ** CW - 1);
        m_d  = (m_a > m_b) ? m_a - m_b : m_b - m_a;
        m_al = (m_d > th);
      end
      pe = (in_a || in_b) ? ~(path_out ^ in_b) : 1'b0;
      check("busy", busy, k <= DoneRel);
      check("ht_in1", ht_in1, (k >= MeasA1 + 1 && k <= DoneRel - 1));
      check("ht_in2", ht_in2, (k >= MeasA1 + 1 && k <= DoneRel - 1));
      check("done", done, k == DoneRel);
      check("path_in", path_in, pe);
      check_results("run");
    end
    logging = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    d_off = 5'd8; d_on = 5'd12; inv_on = 1'b1;
    rst = 1'b1; start = 1'b0; abort = 1'b0; thresh = '0; sat_en = 1'b0;
    m_a = 0; m_b = 0; m_d = 0; m_al = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ht1", ht_in1, 0);
    check("rst_path_in", path_in, 0);
    check_results("rst");
    rst = 1'b0;
    tick();

    // Nominal: 8-cycle non-inverting / 12-cycle inverting path, THRESH=1; saturation in parallel
    sat_en = 1'b1;
    run_meas(1, 0, 1'b0);
    sat_en = 1'b0;
    check("nom_cnt_a", cnt_a, 4);
    check("nom_cnt_b", cnt_b, 2);
    check("nom_delta", delta, 2);
    check("nom_alarm", alarm, 1);
    check("sat_cnt_a", cnt_a_s, 7);
    check("sat_cnt_b", cnt_b_s, 7);
    check("sat_delta", delta_s, 0);

    tick();
    run_meas(2, 0, 1'b0);
    check("th2_delta", delta, 2);
    check("th2_alarm", alarm, 0);

    d_on = 5'd8;
    tick();
    run_meas(2, 0, 1'b0);
    check("same_cnt_a", cnt_a, 4);
    check("same_alarm", alarm, 0);

    // Abort somewhere in GAP; previous results must survive and no DONE may follow
    d_on = 5'd12;
    tick();
    run_meas(0, MeasA1 + 1 + int'($urandom_range(0, S - 1)), 1'b0);
    repeat (20) begin
      tick();
      check("abort_nodone", done, 0);
    end

    // Ignored STARTs at cycle 5 and in DONE, then a back-to-back run
    run_meas(1, 0, 1'b1);
    run_meas(2, 0, 1'b0);

    // Reset held 3 cycles inside MEAS_A
    thresh = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (S + 10) tick();
    rst = 1'b1;
    tick();
    m_a = 0; m_b = 0; m_d = 0; m_al = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_ht1", ht_in1, 0);
    check("mrst_ht2", ht_in2, 0);
    check("mrst_path_in", path_in, 0);
    check_results("mrst");
    tick();
    tick();
    rst = 1'b0;
    check("mrst_idle0", busy, 0);
    tick();
    check("mrst_idle1", busy, 0);
    tick();
    run_meas(1, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      d_off = 5'($urandom_range(2, 12));
      d_on  = 5'($urandom_range(2, 12));
      run_meas(int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DoneRel - 1)) : 0, 1'b0);
      repeat ($urandom_range(1, 5)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
